// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding and load-use hazard control for the EX stage of the 5-stage MIPS core.
// Tracks destination/write-enable state for ID/EX, EX/MEM and MEM/WB and drives the EX mux selects.
module fwd_hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // ID/EX
  logic [REG_W-1:0] exRs;
  logic [REG_W-1:0] exRt;
  logic [REG_W-1:0] exDest;
  logic             exRegWrite;
  logic             exMemRead;
  // EX/MEM
  logic [REG_W-1:0] memDest;
  logic             memRegWrite;
  // MEM/WB
  logic [REG_W-1:0] wbDest;
  logic             wbRegWrite;

  logic [CNT_W-1:0] stallCount;
  logic             insertBubble;

  // Producers writing $0 never forward, so the enables are qualified here once.
  logic memFwdValid;
  logic wbFwdValid;

  assign memFwdValid = memRegWrite && (memDest != '0);
  assign wbFwdValid  = wbRegWrite  && (wbDest  != '0);

  always_comb begin
    forward_a = FWD_NONE;
    if (memFwdValid && (memDest == exRs)) begin
      forward_a = FWD_MEM;
    end else if (wbFwdValid && (wbDest == exRs)) begin
      forward_a = FWD_WB;
    end
  end

  always_comb begin
    forward_b = FWD_NONE;
    if (memFwdValid && (memDest == exRt)) begin
      forward_b = FWD_MEM;
    end else if (wbFwdValid && (wbDest == exRt)) begin
      forward_b = FWD_WB;
    end
  end

  // A load in EX whose result the ID instruction needs cannot be forwarded in time.
  always_comb begin
    stall = 1'b0;
    if (exMemRead && (exDest != '0) && ((exDest == id_rs) || (exDest == id_rt))) begin
      stall = 1'b1;
    end
  end

  assign insertBubble = stall || flush;

  always_ff @(posedge clk) begin
    if (!reset) begin
      exRs        <= '0;
      exRt        <= '0;
      exDest      <= '0;
      exRegWrite  <= 1'b0;
      exMemRead   <= 1'b0;
      memDest     <= '0;
      memRegWrite <= 1'b0;
      wbDest      <= '0;
      wbRegWrite  <= 1'b0;
    end else begin
      memDest     <= exDest;
      memRegWrite <= exRegWrite;
      wbDest      <= memDest;
      wbRegWrite  <= memRegWrite;
      if (insertBubble) begin
        exRs       <= '0;
        exRt       <= '0;
        exDest     <= '0;
        exRegWrite <= 1'b0;
        exMemRead  <= 1'b0;
      end else begin
        exRs       <= id_rs;
        exRt       <= id_rt;
        exDest     <= id_dest;
        exRegWrite <= id_regwrite;
        exMemRead  <= id_memread;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stallCount <= '0;
    end else if (stall && (stallCount != CNT_MAX)) begin
      stallCount <= stallCount + CNT_W'(1);
    end
  end

  assign stall_count = stallCount;

endmodule
